// File: rtl/snake_pkg.sv
// Shared constants for the snake game: direction encodings, PS/2 scan codes
// and the scan parser state type. The game core and renderer use the same
// direction constants.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b11;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } parse_state_t;

  // Opposite directions differ in both bits, so a reversal is a full inversion.
  function automatic logic is_reversal(input logic [1:0] req, input logic [1:0] ref_dir);
    return req == (ref_dir ^ 2'b11);
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Game step timebase: counts 0..TICK_DIV-1 and flags the terminal count.
// 'clear' forces the count to 0, 'hold' freezes it; both suppress the tick.
module game_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic hold,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running wrap counter with clear taking priority over hold.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX) && !hold && !clear;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input controller: PS/2 scan-code parser, 2-entry turn queue with
// reversal rejection, and registered direction/step outputs.
// Optional pause on the space key is compiled in with SNAKE_PAUSE_EN.
module snake_input_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       step,
  output logic       paused
);

  parse_state_t state_q, state_d;
  logic         make_vld;
  logic         make_plain;
  logic         req_vld;
  logic [1:0]   req_dir;
  logic [1:0]   q0, q1;
  logic [1:0]   q_cnt;
  logic [1:0]   ref_dir;
  logic         push, pop;
  logic         tick;
  logic         hold;

  // Parser state register; a partial prefix is dropped on reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= PS_IDLE;
    else          state_q <= state_d;
  end

  // Parser next state: prefixes move forward, any byte ends a break sequence.
  always_comb begin
    state_d = state_q;
    if (ps2_byte_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (ps2_byte == SC_EXT)      state_d = PS_EXT;
          else if (ps2_byte == SC_BRK) state_d = PS_BRK;
        end
        PS_EXT: begin
          if (ps2_byte == SC_BRK)      state_d = PS_EXT_BRK;
          else if (ps2_byte != SC_EXT) state_d = PS_IDLE;
        end
        PS_BRK, PS_EXT_BRK: state_d = PS_IDLE;
      endcase
    end
  end

  // Parser outputs: a make code is any non-prefix byte seen in IDLE or EXT.
  always_comb begin
    make_vld   = 1'b0;
    make_plain = 1'b0;
    if (ps2_byte_valid && ps2_byte != SC_EXT && ps2_byte != SC_BRK) begin
      case (state_q)
        PS_IDLE: begin
          make_vld   = 1'b1;
          make_plain = 1'b1;
        end
        PS_EXT:  make_vld = 1'b1;
        default: ;
      endcase
    end
  end

  // Arrow-key decode; the E0 prefix does not change the meaning.
  always_comb begin
    req_vld = make_vld;
    req_dir = DIR_UP;
    case (ps2_byte)
      SC_UP:    req_dir = DIR_UP;
      SC_RIGHT: req_dir = DIR_RIGHT;
      SC_DOWN:  req_dir = DIR_DOWN;
      SC_LEFT:  req_dir = DIR_LEFT;
      default:  req_vld = 1'b0;
    endcase
  end

  // New turns are checked against the last queued direction, not the live one.
  always_comb begin
    ref_dir = dir;
    if (q_cnt == 2'd2)      ref_dir = q1;
    else if (q_cnt == 2'd1) ref_dir = q0;
  end

  assign push = req_vld && !game_over && (req_dir != ref_dir)
                && !is_reversal(req_dir, ref_dir) && (q_cnt != 2'd2);
  assign pop  = tick && (q_cnt != 2'd0);

  // Turn FIFO; a push coinciding with a pop lands in the freed head slot.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      q0    <= DIR_UP;
      q1    <= DIR_UP;
      q_cnt <= 2'd0;
    end else if (game_over) begin
      q_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= req_dir;
          else               q1 <= req_dir;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: q0 <= req_dir;
        default: ;
      endcase
    end
  end

  // Step strobe and new direction are registered together.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      dir  <= DIR_UP;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (pop) dir <= q0;
    end
  end

`ifdef SNAKE_PAUSE_EN
  logic paused_q;
  logic space_make;

  assign space_make = make_plain && (ps2_byte == SC_SPACE);

  // Space toggles pause; game over always forces it off.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)       paused_q <= 1'b0;
    else if (game_over) paused_q <= 1'b0;
    else if (space_make) paused_q <= !paused_q;
  end

  assign paused = paused_q;
  assign hold   = paused_q;
`else
  logic unused_plain;
  assign unused_plain = make_plain;
  assign paused       = 1'b0;
  assign hold         = 1'b0;
`endif

  game_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .hold    (hold),
    .clear   (game_over),
    .tick    (tick)
  );

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Bench for snake_input_ctrl: directed scenarios followed by random scan-code
// traffic, all compared every cycle against a queue-based reference model.
module tb_snake_input_ctrl;

  localparam int TD = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_byte_valid = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] dir;
  logic       step;
  logic       paused;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_cnt;
  logic [1:0] m_q[$];
  logic [1:0] m_dir;
  logic       m_step;
  logic       m_paused;
  logic       m_ext, m_brk;

  snake_input_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .ps2_byte      (ps2_byte),
    .ps2_byte_valid(ps2_byte_valid),
    .game_over     (game_over),
    .dir           (dir),
    .step          (step),
    .paused        (paused)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_q.delete(); m_dir = 2'b00; m_step = 1'b0;
    m_paused = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  // One clock edge of the game rules, evaluated on pre-edge values.
  task automatic model_edge(input logic [7:0] b, input logic v, input logic go);
    logic       tk, rv, sp, acc;
    logic [1:0] rq, rf;
    tk = (m_cnt == TD - 1) && !go && !m_paused;
    rv = 1'b0; sp = 1'b0; rq = 2'b00;
    if (v) begin
      if (m_brk) begin
        m_brk = 1'b0; m_ext = 1'b0;
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0)     m_brk = 1'b1;
      else begin
        rv = 1'b1;
        case (b)
          8'h75: rq = 2'b00;
          8'h74: rq = 2'b01;
          8'h72: rq = 2'b11;
          8'h6B: rq = 2'b10;
          default: rv = 1'b0;
        endcase
        sp = !m_ext && (b == 8'h29);
        m_ext = 1'b0;
      end
    end
    rf  = (m_q.size() > 0) ? m_q[$] : m_dir;
    acc = rv && !go && (rq != rf) && (rq != ~rf) && (m_q.size() < 2);
    m_step = tk;
    if (tk && m_q.size() > 0) m_dir = m_q.pop_front();
    if (acc) m_q.push_back(rq);
    if (go) m_q.delete();
    if (go) m_cnt = 0;
    else if (!m_paused) m_cnt = (m_cnt + 1) % TD;
`ifdef SNAKE_PAUSE_EN
    m_paused = go ? 1'b0 : (m_paused ^ sp);
`else
    if (sp) m_paused = 1'b0;
`endif
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic clk_step(input logic [7:0] b, input logic v);
    ps2_byte = b; ps2_byte_valid = v;
    @(posedge CLOCK_50);
    model_edge(b, v, game_over);
    #1;
    ps2_byte_valid = 1'b0;
    check("step", {7'd0, step}, {7'd0, m_step});
    check("dir", {6'd0, dir}, {6'd0, m_dir});
    check("paused", {7'd0, paused}, {7'd0, m_paused});
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    model_reset();
    check("rst_dir", {6'd0, dir}, 8'h00);
    check("rst_step", {7'd0, step}, 8'h00);
    check("rst_paused", {7'd0, paused}, 8'h00);
    repeat (2) @(posedge CLOCK_50);
    #1 RESET_N = 1'b1;
  endtask

  // Idle until the DUT steps; returns the cycles taken (bounded).
  task automatic run_to_step(output int n);
    n = 0;
    do begin
      clk_step(8'h00, 1'b0);
      n++;
    end while (!step && n < 4 * TD);
    check("step_seen", {7'd0, step}, 8'h01);
  endtask

  initial begin
    int n, nsteps;
    logic [1:0] saved;
    logic [7:0] pool [9];
    pool = '{8'h75, 8'h74, 8'h72, 8'h6B, 8'hE0, 8'hF0, 8'h29, 8'h1C, 8'h75};

    @(posedge CLOCK_50);
    #1;
    do_reset();

    // first step exactly TD cycles after release, then every TD
    run_to_step(n);
    check("first_step_cyc", 8'(n), 8'(TD));
    check("first_dir", {6'd0, dir}, 8'h00);
    run_to_step(n);
    check("period", 8'(n), 8'(TD));

    // extended make E0 74 -> right
    clk_step(8'hE0, 1'b1);
    clk_step(8'h74, 1'b1);
    run_to_step(n);
    check("ext_make", {6'd0, dir}, 8'h01);

    // extended break E0 F0 74 is discarded; reversal 6B dropped
    clk_step(8'hE0, 1'b1);
    clk_step(8'hF0, 1'b1);
    clk_step(8'h74, 1'b1);
    clk_step(8'h6B, 1'b1);
    run_to_step(n);
    check("rev_1", {6'd0, dir}, 8'h01);
    run_to_step(n);
    check("rev_2", {6'd0, dir}, 8'h01);

    // two queued turns, third dropped as queue is full
    clk_step(8'h72, 1'b1);
    clk_step(8'h6B, 1'b1);
    clk_step(8'h75, 1'b1);
    run_to_step(n);
    check("turn_1", {6'd0, dir}, 8'h03);
    run_to_step(n);
    check("turn_2", {6'd0, dir}, 8'h02);
    run_to_step(n);
    check("turn_full", {6'd0, dir}, 8'h02);

    // push in the same cycle the queue pops
    clk_step(8'h75, 1'b1);
    n = 0;
    while (m_cnt != TD - 1 && n < 2 * TD) begin
      clk_step(8'h00, 1'b0);
      n++;
    end
    clk_step(8'h74, 1'b1);
    check("sim_step", {7'd0, step}, 8'h01);
    check("sim_dir", {6'd0, dir}, 8'h00);
    run_to_step(n);
    check("sim_next", {6'd0, dir}, 8'h01);

`ifdef SNAKE_PAUSE_EN
    clk_step(8'h29, 1'b1);
    check("pause_on", {7'd0, paused}, 8'h01);
    nsteps = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      clk_step(8'h00, 1'b0);
      if (step) nsteps++;
    end
    check("pause_nostep", 8'(nsteps), 8'h00);
    clk_step(8'h29, 1'b1);
    check("pause_off", {7'd0, paused}, 8'h00);
    run_to_step(n);
    clk_step(8'h29, 1'b1);
`endif

    // game over: no steps, queue flushed, pause cleared, restart from 0
    saved = m_dir;
    clk_step(8'h72, 1'b1);
    game_over = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      clk_step(8'h00, 1'b0);
      if (step) nsteps++;
    end
    check("go_nostep", 8'(nsteps), 8'h00);
    check("go_paused", {7'd0, paused}, 8'h00);
    game_over = 1'b0;
    run_to_step(n);
    check("go_restart", 8'(n), 8'(TD));
    check("go_flushed", {6'd0, dir}, {6'd0, saved});

    // reset in the middle of a break prefix, then a plain make
    clk_step(8'hF0, 1'b1);
    do_reset();
    clk_step(8'h74, 1'b1);
    run_to_step(n);
    check("midrst_dir", {6'd0, dir}, 8'h01);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) game_over = ~game_over;
      if ($urandom_range(0, 3) == 0)
        clk_step(pool[$urandom_range(0, 8)], 1'b1);
      else
        clk_step(8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
